// File: rtl/instruction_sender_if.sv
// rtl/instruction_sender_if.sv - request handshake and set_bit/input_bit link bundle
interface instruction_sender_if;
    logic        start;
    logic [10:0] data;
    logic        link_reset_req;
    logic        set_bit;
    logic        input_bit;
    logic        rx_reset;
    logic        busy;
    logic        done;

    modport master (
        output start, data, link_reset_req,
        input  set_bit, input_bit, rx_reset, busy, done
    );

    modport slave (
        input  start, data, link_reset_req,
        output set_bit, input_bit, rx_reset, busy, done
    );
endinterface

// File: rtl/instruction_sender.sv
// rtl/instruction_sender.sv - serial set_bit/input_bit instruction transmitter
// Frames are start + 11 data bits (MSB first) + stop; reset forces a link-reset frame.
module instruction_sender #(
    parameter int HALF_CLKS = 50,
    parameter int GAP_CLKS  = 100
) (
    input  logic                clk,
    input  logic                reset,
    instruction_sender_if.slave link
);
    localparam int CNT_MAX = (HALF_CLKS > GAP_CLKS) ? HALF_CLKS : GAP_CLKS;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_CLKS - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CLKS - 1);
    localparam logic [3:0]    LAST_IDX  = 4'd12;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOW  = 2'd1;
    localparam logic [1:0] S_HIGH = 2'd2;
    localparam logic [1:0] S_GAP  = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    idx_q, idx_d;
    logic [10:0]   shift_q, shift_d;
    logic          lr_q, lr_d;
    logic          set_bit_q, set_bit_d;
    logic          input_bit_q, input_bit_d;
    logic          rx_reset_q, rx_reset_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        lr_d        = lr_q;
        set_bit_d   = set_bit_q;
        input_bit_d = input_bit_q;
        rx_reset_d  = rx_reset_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                // link-reset wins; a simultaneous start is dropped
                if (link.link_reset_req || link.start) begin
                    state_d     = S_LOW;
                    cnt_d       = '0;
                    idx_d       = '0;
                    lr_d        = link.link_reset_req;
                    shift_d     = link.link_reset_req ? 11'd0 : link.data;
                    rx_reset_d  = link.link_reset_req;
                    input_bit_d = 1'b0;
                    busy_d      = 1'b1;
                end
            end
            S_LOW: begin
                if (cnt_q == HALF_LAST) begin
                    state_d   = S_HIGH;
                    cnt_d     = '0;
                    set_bit_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_HIGH: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d     = '0;
                    set_bit_d = 1'b0;
                    if (lr_q || idx_q == LAST_IDX) begin
                        state_d    = S_GAP;
                        rx_reset_d = 1'b0;
                    end else begin
                        // shifted-out zeros naturally supply the stop bit
                        state_d     = S_LOW;
                        idx_d       = idx_q + 4'd1;
                        input_bit_d = shift_q[10];
                        shift_d     = {shift_q[9:0], 1'b0};
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_LOW;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            lr_q        <= 1'b1;
            set_bit_q   <= 1'b0;
            input_bit_q <= 1'b0;
            rx_reset_q  <= 1'b1;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            lr_q        <= lr_d;
            set_bit_q   <= set_bit_d;
            input_bit_q <= input_bit_d;
            rx_reset_q  <= rx_reset_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign link.set_bit   = set_bit_q;
    assign link.input_bit = input_bit_q;
    assign link.rx_reset  = rx_reset_q;
    assign link.busy      = busy_q;
    assign link.done      = done_q;
endmodule

// File: doc/instruction_sender.md
# instruction_sender

Serial transmitter for the set_bit/input_bit instruction link. It accepts an 11-bit instruction word on the system clock and generates the set_bit strobe and input_bit data line that the FPGA-side instruction receiver samples on set_bit rising edges. Each frame is a start pulse, 11 data pulses (MSB first), and a stop pulse, after which the receiver's ready is high. A link-reset frame re-synchronises a receiver left mid-frame.

## Interface
- HALF_CLKS, 50: clk cycles per set_bit half-period, minimum 2.
- GAP_CLKS, 100: idle clk cycles with set_bit low after every frame, before done, minimum 1.

- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high.
- start  in  1  request to send data; sampled only when busy=0.
- data  in  11  instruction word, latched when start is accepted.
- link_reset_req  in  1  request for a link-reset frame; sampled only when busy=0.
- set_bit  out  1  link strobe; the receiver acts on its rising edges.
- input_bit  out  1  link data, stable through each set_bit rising edge.
- rx_reset  out  1  receiver reset line, high for the whole link-reset frame.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse at the end of every frame.

## Operation
- States:
  - IDLE.
  - LOW: set_bit=0, counts HALF_CLKS.
  - HIGH: set_bit=1, counts HALF_CLKS.
  - GAP: set_bit=0, counts GAP_CLKS.
- All outputs are registered.
- Data frame has 13 pulses, idx 0..12:
  - idx 0 is the start pulse, input_bit=0.
  - idx 1..11 carry input_bit = latched data[11-idx], so data[10] goes first.
  - idx 12 is the stop pulse, input_bit=0.
- input_bit changes only on entry to LOW, which gives HALF_CLKS of setup and hold around each rising edge.
- Sequencing:
  - LOW → HIGH after HALF_CLKS cycles.
  - HIGH → LOW (next idx) after HALF_CLKS cycles.
  - After HIGH of the last pulse, HIGH → GAP.
  - GAP → IDLE after GAP_CLKS cycles, with done=1 and busy=0 set on that edge.
- Link-reset frame:
  - One pulse only, input_bit=0, rx_reset=1 from the entry edge until the edge where set_bit falls.
  - Then GAP and done, same as a data frame.
- Request priority in IDLE: if link_reset_req=1, a link-reset frame starts and any simultaneous start is dropped, not queued.
- start or link_reset_req while busy=1 is ignored. Changes to data after acceptance are ignored.
- A request asserted in the same cycle as done is accepted, because busy is already 0.
- Reset values: state=LOW of a pending link-reset frame, busy=1, rx_reset=1, set_bit=0, input_bit=0, done=0.
  - Every reset, including one mid-frame, is therefore followed automatically by a link-reset frame once reset is released.
  - This guarantees the receiver's bit counter is cleared.
- Counters use the minimum width for max(HALF_CLKS, GAP_CLKS) and for idx 0..12. They never wrap inside a frame.

## Timing
Let H=HALF_CLKS and G=GAP_CLKS, and let k be the accepting edge (request high, busy=0). On edge k, busy goes to 1 and the first input_bit value appears.

- Pulse n of a data frame: set_bit rises on edge k+(2n+1)H and falls on edge k+(2n+2)H.
- Data frame completion: the last fall is at k+26H. done and busy=0 are on edge k+26H+G.
- Frame length: 26H+G cycles; the next frame can be accepted on edge k+26H+G+1.
- Link-reset frame: set_bit rises at k+H and falls at k+2H, where rx_reset drops. done is at k+2H+G.
- After reset release (first edge r): set_bit rises at r+H-1 and falls at r+2H-1. done is at r+2H+G-1.
- done is high for exactly one cycle. set_bit is never high during IDLE or GAP.

## Test plan
Use H=2, G=3, with a behavioural receiver model attached that samples input_bit on set_bit rising edges and has its reset tied to rx_reset.

1. Release reset, no requests → one set_bit pulse with rx_reset=1; done at r+6; receiver ready=1; busy=0 afterwards.
2. start with data=11'h5A5 at edge k → input_bit at the 13 rising edges is 0,1,0,1,1,0,1,0,0,1,0,1,0. done at k+55. Receiver mbed_data=11'h5A5 and ready=1.
3. Back-to-back: 11'h7FF, then 11'h000 requested on the done cycle → second frame accepted with no extra idle. Receiver holds 11'h000 at the end.
4. start pulsed again mid-frame, and data changed mid-frame → no effect; the transmitted word is the latched value.
5. start and link_reset_req together in IDLE → only a link-reset frame (1 pulse, rx_reset high); done at k+7; start is not sent.
6. Assert reset during pulse 6 of an 11'h155 frame → outputs go to reset values immediately. After release a link-reset frame runs. A new 11'h2AA frame is then received correctly.
